// File: rtl/types_pkg.sv
// Shared channel types: sequencer state encoding, sampling modes, SCA masks
// and the decode helpers used by the sequencer.
package types_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned SCA_W   = 5;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t STATE_INIT            = 4'd0;
    localparam state_t STATE_STOPPED         = 4'd1;
    localparam state_t STATE_SAMPLING_A      = 4'd2;
    localparam state_t STATE_SAMPLING_B      = 4'd3;
    localparam state_t STATE_SAMPLING_C      = 4'd4;
    localparam state_t STATE_SAMPLING_D      = 4'd5;
    localparam state_t STATE_SAMPLING_E      = 4'd6;
    localparam state_t STATE_SAMPLING_A_AND_B = 4'd7;
    localparam state_t STATE_SAMPLING_C_AND_D = 4'd8;
    localparam state_t STATE_SAMPLING_ALL    = 4'd9;
    localparam state_t STATE_READOUT         = 4'd10;

    typedef enum logic [1:0] {
        MODE_SAMPLE1 = 2'b00,
        MODE_SAMPLE2 = 2'b01,
        MODE_RSVD    = 2'b10,
        MODE_SAMPLE4 = 2'b11
    } smode_t;

    // Write-enable mask ordered {E,D,C,B,A}
    typedef logic [SCA_W-1:0] sca_mask_t;

    typedef struct packed {
        logic   valid;
        state_t state;
    } smode_res_t;

    // Sampling states occupy a contiguous code range
    function automatic logic is_sampling(input state_t s);
        return (s >= STATE_SAMPLING_A) && (s <= STATE_SAMPLING_ALL);
    endfunction

    function automatic sca_mask_t state_to_sca_en(input state_t s);
        case (s)
            STATE_SAMPLING_A:       return 5'b00001;
            STATE_SAMPLING_B:       return 5'b00010;
            STATE_SAMPLING_C:       return 5'b00100;
            STATE_SAMPLING_D:       return 5'b01000;
            STATE_SAMPLING_E:       return 5'b10000;
            STATE_SAMPLING_A_AND_B: return 5'b00011;
            STATE_SAMPLING_C_AND_D: return 5'b01100;
            STATE_SAMPLING_ALL:     return 5'b01111;
            default:                return 5'b00000;
        endcase
    endfunction

    // Map an arm request onto a sampling state; valid=0 means reject
    function automatic smode_res_t smode_to_state(input smode_t m,
                                                  input logic [1:0] bank_sel,
                                                  input logic slow_sel);
        smode_res_t r;
        r.valid = 1'b1;
        r.state = STATE_STOPPED;
        case (m)
            MODE_SAMPLE1: begin
                if (slow_sel) begin
                    r.state = STATE_SAMPLING_E;
                end else begin
                    case (bank_sel)
                        2'd0:    r.state = STATE_SAMPLING_A;
                        2'd1:    r.state = STATE_SAMPLING_B;
                        2'd2:    r.state = STATE_SAMPLING_C;
                        default: r.state = STATE_SAMPLING_D;
                    endcase
                end
            end
            MODE_SAMPLE2: begin
                if (slow_sel) r.valid = 1'b0;
                else r.state = bank_sel[1] ? STATE_SAMPLING_C_AND_D : STATE_SAMPLING_A_AND_B;
            end
            MODE_SAMPLE4: begin
                if (slow_sel) r.valid = 1'b0;
                else r.state = STATE_SAMPLING_ALL;
            end
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ch_sample_ctrl_trig_stop_timer.sv
// Trigger edge detect, saturating trigger counter and post-trigger stop
// countdown.
//   trigger_i    : synchronous trigger level
//   run_i        : sequencer is sampling and not being aborted this cycle
//   clr_i        : clear the trigger counter
//   cfg_load_i   : latch stop_delay_i (accepted arm)
//   trig_count_o : triggers seen since last clear
//   done_c_o     : combinational; sequencer must stop at the next edge
module trig_stop_timer #(
    parameter int unsigned TRIG_W = 8,
    parameter int unsigned DLY_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              trigger_i,
    input  logic              run_i,
    input  logic              clr_i,
    input  logic              cfg_load_i,
    input  logic [DLY_W-1:0]  stop_delay_i,
    output logic [TRIG_W-1:0] trig_count_o,
    output logic              done_c_o
);

    logic              trig_prev_q;
    logic [TRIG_W-1:0] count_q, count_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [DLY_W-1:0]  cd_q, cd_d;
    logic              active_q, active_d;
    logic              hit_c;
    logic              start_c;

    assign hit_c   = trigger_i & ~trig_prev_q & run_i;
    assign start_c = hit_c & ~active_q;

    // Zero delay stops straight from the edge cycle; otherwise the
    // countdown is preloaded with delay-1 so it expires on the same edge.
    assign done_c_o = run_i & ((start_c & (dly_q == '0)) | (active_q & (cd_q == '0)));

    always_comb begin
        count_d  = count_q;
        dly_d    = dly_q;
        cd_d     = cd_q;
        active_d = active_q;

        if (cfg_load_i) dly_d = stop_delay_i;

        if (clr_i) begin
            count_d = '0;
        end else if (hit_c && (count_q != '1)) begin
            count_d = count_q + TRIG_W'(1);
        end

        if (!run_i || done_c_o) begin
            active_d = 1'b0;
            cd_d     = '0;
        end else if (start_c) begin
            active_d = 1'b1;
            cd_d     = dly_q - DLY_W'(1);
        end else if (active_q) begin
            cd_d = cd_q - DLY_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            trig_prev_q <= 1'b0;
            count_q     <= '0;
            dly_q       <= '0;
            cd_q        <= '0;
            active_q    <= 1'b0;
        end else begin
            trig_prev_q <= trigger_i;
            count_q     <= count_d;
            dly_q       <= dly_d;
            cd_q        <= cd_d;
            active_q    <= active_d;
        end
    end

    assign trig_count_o = count_q;

endmodule

// File: rtl/ch_sample_ctrl.sv
// Per-channel sampling sequencer: owns the channel state, drives SCA bank
// write enables, coarse counter enable/clear, trigger counting and the
// readout load/shift strobes.
//   arm/disarm/clear/readout_req : command pulses
//   trigger                      : synchronous trigger level
//   mode/bank_sel/slow_sel       : sampling configuration used on arm
//   stop_delay                   : cycles from trigger edge to stop
//   state, sca_en, cnt_en, cnt_clr, ro_load, shift_en : decode of state
//   trig_count                   : saturating trigger count
//   cfg_err                      : one-cycle pulse on a rejected arm
module ch_sample_ctrl
    import types_pkg::*;
#(
    parameter int unsigned TRIG_W    = 8,
    parameter int unsigned DLY_W     = 8,
    parameter int unsigned SHIFT_LEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              disarm,
    input  logic              clear,
    input  logic              readout_req,
    input  logic              trigger,
    input  logic [1:0]        mode,
    input  logic [1:0]        bank_sel,
    input  logic              slow_sel,
    input  logic [DLY_W-1:0]  stop_delay,
    output logic [3:0]        state,
    output logic [4:0]        sca_en,
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic [TRIG_W-1:0] trig_count,
    output logic              ro_load,
    output logic              shift_en,
    output logic              cfg_err
);

    localparam int unsigned RO_CNT_W = $clog2(SHIFT_LEN + 1);

    state_t              state_q, state_d;
    logic [RO_CNT_W-1:0] ro_cnt_q, ro_cnt_d;
    logic                cfg_err_q, cfg_err_d;
    logic                cfg_load_c;
    logic                run_c;
    logic                clr_c;
    logic                done_c;
    smode_res_t          arm_res_c;

    assign arm_res_c = smode_to_state(smode_t'(mode), bank_sel, slow_sel);

    // An abort in the same cycle suppresses trigger counting
    assign run_c = is_sampling(state_q) & ~clear & ~disarm;
    assign clr_c = (state_q == STATE_INIT) | (state_d == STATE_INIT);

    trig_stop_timer #(
        .TRIG_W (TRIG_W),
        .DLY_W  (DLY_W)
    ) u_timer (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .trigger_i    (trigger),
        .run_i        (run_c),
        .clr_i        (clr_c),
        .cfg_load_i   (cfg_load_c),
        .stop_delay_i (stop_delay),
        .trig_count_o (trig_count),
        .done_c_o     (done_c)
    );

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        ro_cnt_d   = '0;
        cfg_err_d  = 1'b0;
        cfg_load_c = 1'b0;
        case (state_q)
            STATE_INIT: state_d = STATE_STOPPED;
            STATE_STOPPED: begin
                if (clear) begin
                    state_d = STATE_INIT;
                end else if (arm) begin
                    if (arm_res_c.valid) begin
                        state_d    = arm_res_c.state;
                        cfg_load_c = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else if (readout_req) begin
                    state_d = STATE_READOUT;
                end
            end
            STATE_READOUT: begin
                if (clear) begin
                    state_d = STATE_INIT;
                end else if (ro_cnt_q == RO_CNT_W'(SHIFT_LEN)) begin
                    state_d = STATE_STOPPED;
                end else begin
                    ro_cnt_d = ro_cnt_q + RO_CNT_W'(1);
                end
            end
            default: begin
                if (is_sampling(state_q)) begin
                    if (clear)                 state_d = STATE_INIT;
                    else if (disarm || done_c) state_d = STATE_STOPPED;
                end else begin
                    state_d = STATE_INIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= STATE_INIT;
            ro_cnt_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ro_cnt_q  <= ro_cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Outputs decode directly from the state register
    assign state    = state_q;
    assign sca_en   = state_to_sca_en(state_q);
    assign cnt_en   = is_sampling(state_q);
    assign cnt_clr  = (state_q == STATE_INIT);
    assign ro_load  = (state_q == STATE_READOUT) && (ro_cnt_q == '0);
    assign shift_en = (state_q == STATE_READOUT) && (ro_cnt_q != '0);
    assign cfg_err  = cfg_err_q;

endmodule
